// File: rtl/rx_ctrl_unit.sv
// Receive-path control FSM for USB full-speed: frames packets, checks SYNC, strobes FIFO writes, flags errors.
// Optional per-packet stored-byte counter output enabled with `define RX_BYTE_CNT_EN.
module rx_ctrl_unit #(
    parameter logic [7:0]  SYNC_BYTE     = 8'h80,
    parameter int unsigned BITS_PER_BYTE = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error
`ifdef RX_BYTE_CNT_EN
    ,
    output logic [7:0] byte_count
`endif
);

    localparam int unsigned CNT_W = (BITS_PER_BYTE > 1) ? $clog2(BITS_PER_BYTE) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SYNC_RX,
        SYNC_CHK,
        DATA_RX,
        STORE,
        EOP_WAIT,
        ERR_EOP_WAIT,
        ERR_IDLE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   bit_cnt_nxt;
    logic               eop_seen;
    logic               eop_seen_nxt;
    logic               se_eop;

    assign se_eop = shift_enable & eop;

    // Next-state decode; byte_received outranks a coincident EOP sample.
    always_comb begin
        state_nxt    = state;
        eop_seen_nxt = eop_seen;
        case (state)
            IDLE: begin
                if (d_edge) state_nxt = SYNC_RX;
            end
            SYNC_RX: begin
                if (byte_received) begin
                    state_nxt = SYNC_CHK;
                end else if (se_eop) begin
                    state_nxt    = ERR_EOP_WAIT;
                    eop_seen_nxt = 1'b1;
                end
            end
            SYNC_CHK: begin
                if (rcv_data == SYNC_BYTE) begin
                    state_nxt = DATA_RX;
                end else begin
                    state_nxt    = ERR_EOP_WAIT;
                    eop_seen_nxt = 1'b0;
                end
            end
            DATA_RX: begin
                if (byte_received) begin
                    state_nxt = STORE;
                end else if (se_eop) begin
                    if (bit_cnt == '0) begin
                        state_nxt = EOP_WAIT;
                    end else begin
                        state_nxt    = ERR_EOP_WAIT;
                        eop_seen_nxt = 1'b1;
                    end
                end
            end
            STORE: begin
                state_nxt = DATA_RX;
            end
            EOP_WAIT: begin
                if (d_edge) state_nxt = IDLE;
            end
            ERR_EOP_WAIT: begin
                // Bad SYNC lands here before the EOP; the line-idle edge only counts after it.
                if (!eop_seen) begin
                    if (se_eop) eop_seen_nxt = 1'b1;
                end else if (d_edge) begin
                    state_nxt = ERR_IDLE;
                end
            end
            ERR_IDLE: begin
                if (d_edge) state_nxt = SYNC_RX;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bit position within the current data byte.
    always_comb begin
        bit_cnt_nxt = '0;
        if (state == DATA_RX || state == STORE) begin
            if (byte_received) begin
                bit_cnt_nxt = '0;
            end else if (shift_enable && !eop) begin
                bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end else begin
                bit_cnt_nxt = bit_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            eop_seen <= 1'b0;
            rcving   <= 1'b0;
            w_enable <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            eop_seen <= eop_seen_nxt;
            rcving   <= !(state_nxt == IDLE || state_nxt == ERR_IDLE);
            w_enable <= (state == STORE);
            r_error  <= (state_nxt == ERR_EOP_WAIT || state_nxt == ERR_IDLE);
        end
    end

`ifdef RX_BYTE_CNT_EN
    // Stored bytes in the current packet, saturating; cleared on each new SYNC_RX entry.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            byte_count <= 8'h00;
        end else if (state_nxt == SYNC_RX && state != SYNC_RX) begin
            byte_count <= 8'h00;
        end else if (state == STORE && byte_count != 8'hFF) begin
            byte_count <= byte_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rx_ctrl_unit.sv
// Directed self-checking bench for rx_ctrl_unit; byte_count checks compile in with RX_BYTE_CNT_EN.
module tb_rx_ctrl_unit;

    logic       clk;
    logic       n_rst;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic       byte_received;
    logic [7:0] rcv_data;
    logic       rcving;
    logic       w_enable;
    logic       r_error;
`ifdef RX_BYTE_CNT_EN
    logic [7:0] byte_count;
`endif

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;

    rx_ctrl_unit dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_edge       (d_edge),
        .eop          (eop),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .rcv_data     (rcv_data),
        .rcving       (rcving),
        .w_enable     (w_enable),
        .r_error      (r_error)
`ifdef RX_BYTE_CNT_EN
        ,
        .byte_count   (byte_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, let the edge take them, settle 1 time unit, tally write strobes.
    task automatic cyc(input logic de, input logic e, input logic se, input logic br);
        d_edge        = de;
        eop           = e;
        shift_enable  = se;
        byte_received = br;
        @(posedge clk);
        #1;
        d_edge        = 1'b0;
        eop           = 1'b0;
        shift_enable  = 1'b0;
        byte_received = 1'b0;
        if (w_enable === 1'b1) we_cnt++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rcv_data = b;
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        n_rst         = 1'b0;
        d_edge        = 1'b0;
        eop           = 1'b0;
        shift_enable  = 1'b0;
        byte_received = 1'b0;
        rcv_data      = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rcving", 32'(rcving), 32'd0);
        chk("rst_w_enable", 32'(w_enable), 32'd0);
        chk("rst_r_error", 32'(r_error), 32'd0);
`ifdef RX_BYTE_CNT_EN
        chk("rst_byte_count", 32'(byte_count), 32'd0);
`endif
        n_rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_rcving", 32'(rcving), 32'd0);

        // Good packet: SYNC, A5, 3C, clean EOP, line back to J.
        we_cnt = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("good_rcving_rise", 32'(rcving), 32'd1);
        send_byte(8'h80);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(8'hA5);
        chk("good_we_not_yet", 32'(w_enable), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("good_we_2cyc", 32'(w_enable), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("good_we_one_pulse", 32'(w_enable), 32'd0);
        send_byte(8'h3C);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("good_eop_rcving", 32'(rcving), 32'd1);
        chk("good_eop_r_error", 32'(r_error), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("good_eopwait_rcving", 32'(rcving), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("good_rcving_fall", 32'(rcving), 32'd0);
        chk("good_we_count", 32'(we_cnt), 32'd2);
        chk("good_r_error", 32'(r_error), 32'd0);
`ifdef RX_BYTE_CNT_EN
        chk("good_byte_count", 32'(byte_count), 32'd2);
`endif

        // Bad SYNC: error after check, edge ignored until EOP, sticky until next packet.
        we_cnt = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        send_byte(8'h81);
        chk("badsync_chk_r_error", 32'(r_error), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("badsync_r_error", 32'(r_error), 32'd1);
        chk("badsync_rcving", 32'(rcving), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("badsync_pre_eop_edge", 32'(rcving), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("badsync_eop_rcving", 32'(rcving), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("badsync_erridle_rcving", 32'(rcving), 32'd0);
        chk("badsync_erridle_r_error", 32'(r_error), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("badsync_sticky", 32'(r_error), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("badsync_clear", 32'(r_error), 32'd0);
        chk("badsync_restart_rcving", 32'(rcving), 32'd1);
        chk("badsync_no_we", 32'(we_cnt), 32'd0);

        // EOP mid-byte after 3 data bits.
        send_byte(8'h80);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("midbyte_r_error", 32'(r_error), 32'd1);
        chk("midbyte_rcving", 32'(rcving), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("midbyte_erridle_rcving", 32'(rcving), 32'd0);
        chk("midbyte_erridle_r_error", 32'(r_error), 32'd1);
        chk("midbyte_no_we", 32'(we_cnt), 32'd0);
`ifdef RX_BYTE_CNT_EN
        chk("midbyte_byte_count", 32'(byte_count), 32'd0);
`endif

        // byte_received coincident with EOP sample: byte kept, next EOP is clean.
        we_cnt = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("simul_r_error_clr", 32'(r_error), 32'd0);
        send_byte(8'h80);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rcv_data = 8'h5A;
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk("simul_r_error", 32'(r_error), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("simul_we", 32'(w_enable), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("simul_clean_eop", 32'(r_error), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("simul_rcving_fall", 32'(rcving), 32'd0);
        chk("simul_we_count", 32'(we_cnt), 32'd1);

        // Reset while STORE is pending: outputs drop at once, no strobe follows.
        we_cnt = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        send_byte(8'h80);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(8'hC3);
        n_rst = 1'b0;
        #1;
        chk("midrst_rcving", 32'(rcving), 32'd0);
        chk("midrst_w_enable", 32'(w_enable), 32'd0);
        chk("midrst_r_error", 32'(r_error), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_w_enable_held", 32'(w_enable), 32'd0);
        n_rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst_idle", 32'(rcving), 32'd0);
        chk("midrst_no_we", 32'(we_cnt), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("midrst_restart", 32'(rcving), 32'd1);

        // Long packet of 260 bytes.
        send_byte(8'h80);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        we_cnt = 0;
        for (int i = 0; i < 260; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("long_we_count", 32'(we_cnt), 32'd260);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("long_clean_eop", 32'(r_error), 32'd0);
`ifdef RX_BYTE_CNT_EN
        chk("long_byte_count_sat", 32'(byte_count), 32'hFF);
`endif
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("long_rcving_fall", 32'(rcving), 32'd0);
`ifdef RX_BYTE_CNT_EN
        chk("long_byte_count_hold", 32'(byte_count), 32'hFF);
`endif
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("next_rcving", 32'(rcving), 32'd1);
`ifdef RX_BYTE_CNT_EN
        chk("next_byte_count_clr", 32'(byte_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
